// File: rtl/id_ex_issue.sv
// ---------------------------------------------------------------------------
// id_ex_issue
//
// Purpose:
//    ID/EX issue register for a five-stage in-order pipeline. Captures a
//    decoded instruction from the decode stage, holds it while the hazard
//    unit stalls, turns it into a bubble on a branch/jump flush, and drives
//    the ALU operands one cycle later. Register operands can be bypassed
//    from the EX/MEM and MEM/WB stages. The operands are resolved
//    combinationally against the indices held in the EX slot, so a stalled
//    instruction keeps picking up the newest bypass values.
//
// Optional feature:
//    ID_EX_FORWARD_EN - when defined, the EX/MEM and MEM/WB bypass network
//    is compiled in. When undefined, the operands come straight from the
//    register-file values captured in the EX slot, and the exmem_* and
//    memwb_* inputs are ignored.
//
// Ports:
//    clk            in   1   clock, rising-edge active
//    rstn           in   1   asynchronous active-low reset
//    in_valid       in   1   decode presents a valid instruction
//    in_ready       out  1   issue register accepts this cycle (= !stall)
//    stall          in   1   hold EX contents
//    flush          in   1   kill; EX becomes a bubble
//    id_alu_func    in   4   ALU operation code
//    id_rs1/rs2/rd  in   5   register indices
//    id_rs1_data, id_rs2_data, id_imm, id_pc   in 32  operands, immediate, PC
//    id_src1_sel    in   1   0 = rs1, 1 = PC
//    id_src2_sel    in   1   0 = rs2, 1 = immediate
//    id_rf_we       in   1   instruction writes rd
//    exmem_rd/_rf_we/_ans    EX/MEM bypass source
//    memwb_rd/_rf_we/_data   MEM/WB bypass source
//    ex_valid       out  1   EX slot holds a live instruction
//    alu_func       out  4   ALU operation code
//    alu_src1/2     out  32  ALU operands
//    ex_rd          out  5   destination register
//    ex_rf_we       out  1   destination write enable
//    ex_store_data  out  32  forwarded rs2 value for stores
//    bubble_cnt     out  16  saturating count of bubble cycles since reset
// ---------------------------------------------------------------------------
module id_ex_issue (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        stall,
   input  logic        flush,
   input  logic [3:0]  id_alu_func,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_pc,
   input  logic        id_src1_sel,
   input  logic        id_src2_sel,
   input  logic        id_rf_we,
   input  logic [4:0]  exmem_rd,
   input  logic        exmem_rf_we,
   input  logic [31:0] exmem_ans,
   input  logic [4:0]  memwb_rd,
   input  logic        memwb_rf_we,
   input  logic [31:0] memwb_data,
   output logic        ex_valid,
   output logic [3:0]  alu_func,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [4:0]  ex_rd,
   output logic        ex_rf_we,
   output logic [31:0] ex_store_data,
   output logic [15:0] bubble_cnt
);

   // EX slot registers and their next-state values
   logic        exValid_q,    exValid_d;
   logic [3:0]  exFunc_q,     exFunc_d;
   logic [4:0]  exRs1_q,      exRs1_d;
   logic [4:0]  exRs2_q,      exRs2_d;
   logic [4:0]  exRd_q,       exRd_d;
   logic [31:0] exRs1Data_q,  exRs1Data_d;
   logic [31:0] exRs2Data_q,  exRs2Data_d;
   logic [31:0] exImm_q,      exImm_d;
   logic [31:0] exPc_q,       exPc_d;
   logic        exSrc1Sel_q,  exSrc1Sel_d;
   logic        exSrc2Sel_q,  exSrc2Sel_d;
   logic        exRfWe_q,     exRfWe_d;
   logic [15:0] bubbleCnt_q,  bubbleCnt_d;

   logic [31:0] fwdRs1;
   logic [31:0] fwdRs2;

   // The decode stage may hand over a new instruction whenever the hazard
   // unit is not holding the EX slot.
   assign in_ready = !stall;

   // Next-state selection for the EX slot. Flush wins over everything and
   // produces an all-zero bubble. Without flush, a stall holds the slot and
   // otherwise the decoded instruction is captured. A capture with
   // in_valid low is also a fully zeroed bubble, so dead instructions never
   // leak stale indices into the bypass comparators.
   always_comb begin
      exValid_d   = exValid_q;
      exFunc_d    = exFunc_q;
      exRs1_d     = exRs1_q;
      exRs2_d     = exRs2_q;
      exRd_d      = exRd_q;
      exRs1Data_d = exRs1Data_q;
      exRs2Data_d = exRs2Data_q;
      exImm_d     = exImm_q;
      exPc_d      = exPc_q;
      exSrc1Sel_d = exSrc1Sel_q;
      exSrc2Sel_d = exSrc2Sel_q;
      exRfWe_d    = exRfWe_q;
      if (flush || (!stall && !in_valid)) begin
         exValid_d   = 1'b0;
         exFunc_d    = 4'b0000;
         exRs1_d     = 5'd0;
         exRs2_d     = 5'd0;
         exRd_d      = 5'd0;
         exRs1Data_d = 32'd0;
         exRs2Data_d = 32'd0;
         exImm_d     = 32'd0;
         exPc_d      = 32'd0;
         exSrc1Sel_d = 1'b0;
         exSrc2Sel_d = 1'b0;
         exRfWe_d    = 1'b0;
      end else if (!stall) begin
         exValid_d   = 1'b1;
         exFunc_d    = id_alu_func;
         exRs1_d     = id_rs1;
         exRs2_d     = id_rs2;
         exRd_d      = id_rd;
         exRs1Data_d = id_rs1_data;
         exRs2Data_d = id_rs2_data;
         exImm_d     = id_imm;
         exPc_d      = id_pc;
         exSrc1Sel_d = id_src1_sel;
         exSrc2Sel_d = id_src2_sel;
         exRfWe_d    = id_rf_we;
      end
   end

   // Bubble counter: counts every edge on which the EX slot is empty and
   // sticks at all-ones instead of wrapping.
   always_comb begin
      bubbleCnt_d = bubbleCnt_q;
      if (!exValid_q && (bubbleCnt_q != 16'hFFFF)) begin
         bubbleCnt_d = bubbleCnt_q + 16'd1;
      end
   end

   // State registers. Reset empties the slot immediately, discarding any
   // instruction that was being held by a stall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exValid_q   <= 1'b0;
         exFunc_q    <= 4'b0000;
         exRs1_q     <= 5'd0;
         exRs2_q     <= 5'd0;
         exRd_q      <= 5'd0;
         exRs1Data_q <= 32'd0;
         exRs2Data_q <= 32'd0;
         exImm_q     <= 32'd0;
         exPc_q      <= 32'd0;
         exSrc1Sel_q <= 1'b0;
         exSrc2Sel_q <= 1'b0;
         exRfWe_q    <= 1'b0;
         bubbleCnt_q <= 16'd0;
      end else begin
         exValid_q   <= exValid_d;
         exFunc_q    <= exFunc_d;
         exRs1_q     <= exRs1_d;
         exRs2_q     <= exRs2_d;
         exRd_q      <= exRd_d;
         exRs1Data_q <= exRs1Data_d;
         exRs2Data_q <= exRs2Data_d;
         exImm_q     <= exImm_d;
         exPc_q      <= exPc_d;
         exSrc1Sel_q <= exSrc1Sel_d;
         exSrc2Sel_q <= exSrc2Sel_d;
         exRfWe_q    <= exRfWe_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

`ifdef ID_EX_FORWARD_EN
   // Operand bypass. The younger EX/MEM result beats MEM/WB, and x0 is
   // never bypassed because it always reads as the register-file value.
   always_comb begin
      fwdRs1 = exRs1Data_q;
      if (exmem_rf_we && (exmem_rd == exRs1_q) && (exmem_rd != 5'd0)) begin
         fwdRs1 = exmem_ans;
      end else if (memwb_rf_we && (memwb_rd == exRs1_q) && (memwb_rd != 5'd0)) begin
         fwdRs1 = memwb_data;
      end
      fwdRs2 = exRs2Data_q;
      if (exmem_rf_we && (exmem_rd == exRs2_q) && (exmem_rd != 5'd0)) begin
         fwdRs2 = exmem_ans;
      end else if (memwb_rf_we && (memwb_rd == exRs2_q) && (memwb_rd != 5'd0)) begin
         fwdRs2 = memwb_data;
      end
   end
`else
   // No bypass network: operands are the register-file values captured at
   // issue. The bypass ports and held indices are gathered here only so the
   // build has no dangling signals.
   logic unusedBypass;
   assign unusedBypass = ^{exmem_rd, exmem_rf_we, exmem_ans,
                           memwb_rd, memwb_rf_we, memwb_data,
                           exRs1_q, exRs2_q};

   always_comb begin
      fwdRs1 = exRs1Data_q;
      fwdRs2 = exRs2Data_q;
   end
`endif

   // Output drive. Store data is always the resolved rs2, because a store
   // uses the immediate for its address and rs2 for its data.
   assign ex_valid      = exValid_q;
   assign alu_func      = exFunc_q;
   assign alu_src1      = exSrc1Sel_q ? exPc_q  : fwdRs1;
   assign alu_src2      = exSrc2Sel_q ? exImm_q : fwdRs2;
   assign ex_rd         = exRd_q;
   assign ex_rf_we      = exRfWe_q;
   assign ex_store_data = fwdRs2;
   assign bubble_cnt    = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// ---------------------------------------------------------------------------
// tb_id_ex_issue
//
// Self-checking bench for id_ex_issue. A table of directed vectors covers
// issue, operand select, bubbles, stall and flush, including the bubble
// counter. Hand-written sequences cover asynchronous reset, a multi-cycle
// stall, reset during a stall, bypass priority (with expectations that
// follow ID_EX_FORWARD_EN), and bubble counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_issue;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic [3:0]  id_alu_func;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        id_src1_sel, id_src2_sel, id_rf_we;
   logic [4:0]  exmem_rd;
   logic        exmem_rf_we;
   logic [31:0] exmem_ans;
   logic [4:0]  memwb_rd;
   logic        memwb_rf_we;
   logic [31:0] memwb_data;
   logic        ex_valid;
   logic [3:0]  alu_func;
   logic [31:0] alu_src1, alu_src2;
   logic [4:0]  ex_rd;
   logic        ex_rf_we;
   logic [31:0] ex_store_data;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_issue dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .id_alu_func(id_alu_func),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc),
      .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel), .id_rf_we(id_rf_we),
      .exmem_rd(exmem_rd), .exmem_rf_we(exmem_rf_we), .exmem_ans(exmem_ans),
      .memwb_rd(memwb_rd), .memwb_rf_we(memwb_rf_we), .memwb_data(memwb_data),
      .ex_valid(ex_valid), .alu_func(alu_func),
      .alu_src1(alu_src1), .alu_src2(alu_src2),
      .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
      .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic        valid;
      logic        stl;
      logic        fls;
      logic [3:0]  func;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1Data;
      logic [31:0] rs2Data;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        s1Sel;
      logic        s2Sel;
      logic        rfWe;
      logic        expValid;
      logic [3:0]  expFunc;
      logic [31:0] expSrc1;
      logic [31:0] expSrc2;
      logic [31:0] expStore;
      logic [4:0]  expRd;
      logic        expRfWe;
      logic [15:0] expCnt;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      in_valid    = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      id_alu_func = 4'd0;
      id_rs1      = 5'd0;
      id_rs2      = 5'd0;
      id_rd       = 5'd0;
      id_rs1_data = 32'd0;
      id_rs2_data = 32'd0;
      id_imm      = 32'd0;
      id_pc       = 32'd0;
      id_src1_sel = 1'b0;
      id_src2_sel = 1'b0;
      id_rf_we    = 1'b0;
      exmem_rd    = 5'd0;
      exmem_rf_we = 1'b0;
      exmem_ans   = 32'd0;
      memwb_rd    = 5'd0;
      memwb_rf_we = 1'b0;
      memwb_data  = 32'd0;
   endtask

   task automatic applyStimulus(input vec_t v);
      in_valid    = v.valid;
      stall       = v.stl;
      flush       = v.fls;
      id_alu_func = v.func;
      id_rs1      = v.rs1;
      id_rs2      = v.rs2;
      id_rd       = v.rd;
      id_rs1_data = v.rs1Data;
      id_rs2_data = v.rs2Data;
      id_imm      = v.imm;
      id_pc       = v.pc;
      id_src1_sel = v.s1Sel;
      id_src2_sel = v.s2Sel;
      id_rf_we    = v.rfWe;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // name valid stall flush func rs1 rs2 rd rs1Data rs2Data imm pc s1 s2 we | valid func src1 src2 store rd we cnt
      vecs[0] = '{"issue_imm", 1,0,0, 4'h1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd3, 32'd100, 0,1,1,
                  1, 4'h1, 32'd10, 32'd3, 32'd20, 5'd3, 1, 16'd1};
      vecs[1] = '{"issue_pc_rs2", 1,0,0, 4'h2, 5'd4, 5'd6, 5'd8, 32'd77, 32'h1234, 32'd9, 32'h40, 1,0,1,
                  1, 4'h2, 32'h40, 32'h1234, 32'h1234, 5'd8, 1, 16'd1};
      vecs[2] = '{"invalid_bubble", 0,0,0, 4'h7, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'd5, 32'h80, 1,1,1,
                  0, 4'h0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 16'd1};
      vecs[3] = '{"issue_all_ones", 1,0,0, 4'hF, 5'd12, 5'd13, 5'd31, 32'hFFFFFFFF, 32'd5, 32'd1, 32'h200, 0,0,0,
                  1, 4'hF, 32'hFFFFFFFF, 32'd5, 32'd5, 5'd31, 0, 16'd2};
      vecs[4] = '{"stall_hold", 1,1,0, 4'h3, 5'd1, 5'd1, 5'd1, 32'd1, 32'd1, 32'd1, 32'd1, 1,1,1,
                  1, 4'hF, 32'hFFFFFFFF, 32'd5, 32'd5, 5'd31, 0, 16'd2};
      vecs[5] = '{"flush_bubble", 1,0,1, 4'h4, 5'd2, 5'd3, 5'd4, 32'd2, 32'd3, 32'd4, 32'd5, 0,0,1,
                  0, 4'h0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 16'd2};
      vecs[6] = '{"issue_after_flush", 1,0,0, 4'h5, 5'd14, 5'd15, 5'd16, 32'd50, 32'd60, 32'd70, 32'd80, 0,1,1,
                  1, 4'h5, 32'd50, 32'd70, 32'd60, 5'd16, 1, 16'd3};
      vecs[7] = '{"stall_flush", 1,1,1, 4'h6, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd9, 32'd9, 0,0,1,
                  0, 4'h0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 16'd3};
      vecs[8] = '{"stall_on_bubble", 1,1,0, 4'h6, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd9, 32'd9, 0,0,1,
                  0, 4'h0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 16'd4};

      // Reset with a valid instruction on the inputs: slot must stay empty.
      clearInputs();
      rstn        = 1'b0;
      in_valid    = 1'b1;
      id_alu_func = 4'h9;
      id_rs1_data = 32'h1111;
      id_imm      = 32'h2222;
      id_src2_sel = 1'b1;
      tick();
      tick();
      checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("rst_alu_func", {28'd0, alu_func}, 32'd0);
      checkOutput("rst_alu_src1", alu_src1, 32'd0);
      checkOutput("rst_alu_src2", alu_src2, 32'd0);
      checkOutput("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
      clearInputs();
      rstn = 1'b1;

      // Table-driven vectors, one rising edge each.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, {31'd0, !vecs[i].stl});
         checkOutput({vecs[i].name, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, vecs[i].expValid});
         checkOutput({vecs[i].name, "_alu_func"}, {28'd0, alu_func}, {28'd0, vecs[i].expFunc});
         checkOutput({vecs[i].name, "_alu_src1"}, alu_src1, vecs[i].expSrc1);
         checkOutput({vecs[i].name, "_alu_src2"}, alu_src2, vecs[i].expSrc2);
         checkOutput({vecs[i].name, "_store"}, ex_store_data, vecs[i].expStore);
         checkOutput({vecs[i].name, "_ex_rd"}, {27'd0, ex_rd}, {27'd0, vecs[i].expRd});
         checkOutput({vecs[i].name, "_ex_rf_we"}, {31'd0, ex_rf_we}, {31'd0, vecs[i].expRfWe});
         checkOutput({vecs[i].name, "_bubble_cnt"}, {16'd0, bubble_cnt}, {16'd0, vecs[i].expCnt});
      end

      // Three-cycle stall: outputs frozen while decode inputs change.
      clearInputs();
      in_valid = 1'b1; id_alu_func = 4'hA; id_rs1_data = 32'd123; id_rs2_data = 32'd456;
      id_rd = 5'd7; id_rf_we = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         stall = 1'b1;
         id_alu_func = 4'h1 + 4'(c); id_rs1_data = 32'd900 + 32'(c);
         #1;
         checkOutput("stall3_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         checkOutput("stall3_func", {28'd0, alu_func}, 32'hA);
         checkOutput("stall3_src1", alu_src1, 32'd123);
         checkOutput("stall3_src2", alu_src2, 32'd456);
         checkOutput("stall3_valid", {31'd0, ex_valid}, 32'd1);
      end

      // Reset during a stall: held instruction is discarded at once, and
      // nothing is captured until the first edge with stall low.
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_stall_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("rst_mid_stall_func", {28'd0, alu_func}, 32'd0);
      checkOutput("rst_mid_stall_cnt", {16'd0, bubble_cnt}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checkOutput("post_rst_stalled_valid", {31'd0, ex_valid}, 32'd0);
      stall = 1'b0;
      tick();
      checkOutput("post_rst_capture_valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("post_rst_capture_src1", alu_src1, 32'd902);
      checkOutput("post_rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

      // Bypass checks on a stalled instruction: rs1=5, rs2=7, src2 = imm.
      clearInputs();
      in_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd7; id_rs1_data = 32'h11;
      id_rs2_data = 32'h22; id_imm = 32'd8; id_src2_sel = 1'b1;
      tick();
      stall = 1'b1;
      exmem_rd = 5'd5; exmem_rf_we = 1'b1; exmem_ans = 32'hAA;
      memwb_rd = 5'd5; memwb_rf_we = 1'b1; memwb_data = 32'hBB;
      tick();
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd_both_src1", alu_src1, 32'hAA);
`else
      checkOutput("fwd_both_src1", alu_src1, 32'h11);
`endif
      exmem_rf_we = 1'b0;
      tick();
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd_memwb_src1", alu_src1, 32'hBB);
`else
      checkOutput("fwd_memwb_src1", alu_src1, 32'h11);
`endif
      memwb_rf_we = 1'b0;
      exmem_rd = 5'd7; exmem_rf_we = 1'b1; exmem_ans = 32'h55;
      #1;
      checkOutput("fwd_store_src2", alu_src2, 32'd8);
      checkOutput("fwd_store_src1_raw", alu_src1, 32'h11);
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd_store_data", ex_store_data, 32'h55);
`else
      checkOutput("fwd_store_data", ex_store_data, 32'h22);
`endif
      exmem_rf_we = 1'b0;
      memwb_rd = 5'd7; memwb_rf_we = 1'b1; memwb_data = 32'h66;
      #1;
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd_store_memwb", ex_store_data, 32'h66);
`else
      checkOutput("fwd_store_memwb", ex_store_data, 32'h22);
`endif

      // x0 is never bypassed even when both stages claim to write it.
      @(negedge clk);
      clearInputs();
      in_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_data = 32'h33; id_rs2_data = 32'h44;
      tick();
      stall = 1'b1;
      exmem_rd = 5'd0; exmem_rf_we = 1'b1; exmem_ans = 32'hAA;
      memwb_rd = 5'd0; memwb_rf_we = 1'b1; memwb_data = 32'hBB;
      #1;
      checkOutput("x0_src1_raw", alu_src1, 32'h33);
      checkOutput("x0_store_raw", ex_store_data, 32'h44);

      // Saturation: fresh reset, then a long run of bubbles.
      @(negedge clk);
      clearInputs();
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      for (int c = 0; c < 65534; c++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("sat_before", {16'd0, bubble_cnt}, 32'hFFFE);
      tick();
      checkOutput("sat_reach", {16'd0, bubble_cnt}, 32'hFFFF);
      for (int c = 0; c < 4465; c++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("sat_hold", {16'd0, bubble_cnt}, 32'hFFFF);
      checkOutput("sat_ex_valid", {31'd0, ex_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
